// File: rtl/pp_loop_tracker.sv
// pp_loop_tracker
//   Tracks one pipelined HLS loop from its FSM state and loop-descriptor
//   signals. It reconstructs loop entry, iteration start/end events,
//   iterations in flight, loop completion and protocol errors. All outputs
//   are registered.
//
// Ports
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   cur_state               DUT FSM state this cycle
//   pre_states_valid        1 = loop must be armed by pre_loop_state0
//   pre_loop_state0         arming state
//   post_states_valid[7:0]  per-slot enable for post_loop_state0..7
//   post_loop_state0..7     loop exit states
//   loop_quit_state         quit decision state
//   iter_start_* / iter_end_*  iteration boundary state, qualifier, stall
//   quit_at_end             1 = quit legal while iterations are in flight
//   finish                  end of simulation, forces IDLE
//   loop_active             FSM in LOOP or DRAIN
//   iter_start_pulse / iter_end_pulse  strobes for counted start/end events
//   start_count / end_count per-invocation totals (saturating)
//   inflight                iterations started and not yet ended
//   invocations             completed invocations (saturating)
//   loop_done               one-cycle completion pulse
//   err_*                   sticky error flags, cleared only by reset
module pp_loop_tracker #(
    parameter int FSM_WIDTH    = 2,
    parameter int CNT_WIDTH    = 16,
    parameter int MAX_INFLIGHT = 8,
    localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FSM_WIDTH-1:0] cur_state,
    input  logic                 pre_states_valid,
    input  logic [FSM_WIDTH-1:0] pre_loop_state0,
    input  logic [7:0]           post_states_valid,
    input  logic [FSM_WIDTH-1:0] post_loop_state0,
    input  logic [FSM_WIDTH-1:0] post_loop_state1,
    input  logic [FSM_WIDTH-1:0] post_loop_state2,
    input  logic [FSM_WIDTH-1:0] post_loop_state3,
    input  logic [FSM_WIDTH-1:0] post_loop_state4,
    input  logic [FSM_WIDTH-1:0] post_loop_state5,
    input  logic [FSM_WIDTH-1:0] post_loop_state6,
    input  logic [FSM_WIDTH-1:0] post_loop_state7,
    input  logic [FSM_WIDTH-1:0] loop_quit_state,
    input  logic [FSM_WIDTH-1:0] iter_start_state,
    input  logic [FSM_WIDTH-1:0] iter_end_state,
    input  logic                 iter_start_enable,
    input  logic                 iter_end_enable,
    input  logic                 iter_start_block,
    input  logic                 iter_end_block,
    input  logic                 quit_at_end,
    input  logic                 finish,
    output logic                 loop_active,
    output logic                 iter_start_pulse,
    output logic                 iter_end_pulse,
    output logic [CNT_WIDTH-1:0] start_count,
    output logic [CNT_WIDTH-1:0] end_count,
    output logic [INF_W-1:0]     inflight,
    output logic [CNT_WIDTH-1:0] invocations,
    output logic                 loop_done,
    output logic                 err_underflow,
    output logic                 err_overflow,
    output logic                 err_incomplete,
    output logic                 err_protocol
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_LOOP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [1:0]           state;
    logic [FSM_WIDTH-1:0] post_arr [8];

    logic start_evt, end_evt, quit_evt, post_hit;
    logic s_cnt, e_cnt;

    // Result of applying this cycle's counted events to the running totals
    logic [CNT_WIDTH-1:0] ar_sc, ar_ec;
    logic [INF_W-1:0]     ar_inf;
    logic                 ar_under, ar_over, ar_sp, ar_ep;

    logic [1:0]           nxt_state;
    logic [CNT_WIDTH-1:0] nxt_sc, nxt_ec, nxt_inv;
    logic [INF_W-1:0]     nxt_inf;
    logic                 nxt_sp, nxt_ep, nxt_done;
    logic                 nxt_under, nxt_over, nxt_inc, nxt_prot;
    logic                 enter, complete;

    assign post_arr[0] = post_loop_state0;
    assign post_arr[1] = post_loop_state1;
    assign post_arr[2] = post_loop_state2;
    assign post_arr[3] = post_loop_state3;
    assign post_arr[4] = post_loop_state4;
    assign post_arr[5] = post_loop_state5;
    assign post_arr[6] = post_loop_state6;
    assign post_arr[7] = post_loop_state7;

    assign start_evt = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign end_evt   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign quit_evt  = (cur_state == loop_quit_state);

    always_comb begin
        post_hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (post_states_valid[i] && (cur_state == post_arr[i])) post_hit = 1'b1;
        end
    end

    // Starts are counted only in LOOP; DRAIN accepts ends only.
    assign s_cnt = (state == S_LOOP) & start_evt;
    assign e_cnt = ((state == S_LOOP) | (state == S_DRAIN)) & end_evt;

    always_comb begin
        ar_sc    = start_count;
        ar_ec    = end_count;
        ar_inf   = inflight;
        ar_under = 1'b0;
        ar_over  = 1'b0;
        ar_sp    = 1'b0;
        ar_ep    = 1'b0;
        if (s_cnt && e_cnt) begin
            // One iteration retires as another begins: occupancy unchanged.
            ar_sc = sat_inc(start_count);
            ar_ec = sat_inc(end_count);
            ar_sp = 1'b1;
            ar_ep = 1'b1;
        end else if (e_cnt) begin
            if (inflight == '0) begin
                ar_under = 1'b1;
            end else begin
                ar_inf = inflight - INF_W'(1);
                ar_ec  = sat_inc(end_count);
                ar_ep  = 1'b1;
            end
        end else if (s_cnt) begin
            ar_sc = sat_inc(start_count);
            ar_sp = 1'b1;
            if (inflight == INF_MAX) ar_over = 1'b1;
            else                     ar_inf  = inflight + INF_W'(1);
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_sc    = start_count;
        nxt_ec    = end_count;
        nxt_inf   = inflight;
        nxt_inv   = invocations;
        nxt_sp    = 1'b0;
        nxt_ep    = 1'b0;
        nxt_done  = 1'b0;
        nxt_under = err_underflow;
        nxt_over  = err_overflow;
        nxt_inc   = err_incomplete;
        nxt_prot  = err_protocol;
        enter     = 1'b0;
        complete  = 1'b0;

        if (finish) begin
            // Abandon whatever is running; totals are kept for inspection.
            nxt_state = S_IDLE;
            if (inflight != '0) nxt_inc = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (end_evt) nxt_prot = 1'b1;
                    if (pre_states_valid && (cur_state == pre_loop_state0)) nxt_state = S_ARMED;
                    else if (!pre_states_valid && start_evt)                enter     = 1'b1;
                end
                S_ARMED: begin
                    if (start_evt) enter = 1'b1;
                end
                S_LOOP: begin
                    nxt_sc    = ar_sc;
                    nxt_ec    = ar_ec;
                    nxt_inf   = ar_inf;
                    nxt_sp    = ar_sp;
                    nxt_ep    = ar_ep;
                    nxt_under = err_underflow | ar_under;
                    nxt_over  = err_overflow | ar_over;
                    if (post_hit && (ar_inf == '0)) begin
                        complete = 1'b1;
                    end else if (quit_evt) begin
                        nxt_state = S_DRAIN;
                        if (!quit_at_end && (ar_inf != '0)) nxt_inc = 1'b1;
                    end
                end
                default: begin // S_DRAIN
                    nxt_ec    = ar_ec;
                    nxt_inf   = ar_inf;
                    nxt_ep    = ar_ep;
                    nxt_under = err_underflow | ar_under;
                    if (start_evt) nxt_prot = 1'b1;
                    if (ar_inf == '0) complete = 1'b1;
                end
            endcase

            // The entering start is iteration 1 of a fresh invocation.
            if (enter) begin
                nxt_state = S_LOOP;
                nxt_sc    = CNT_WIDTH'(1);
                nxt_ec    = '0;
                nxt_inf   = INF_W'(1);
                nxt_sp    = 1'b1;
            end
            if (complete) begin
                nxt_state = S_IDLE;
                nxt_done  = 1'b1;
                nxt_inv   = sat_inc(invocations);
            end
        end
    end

    // ---- registered outputs ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            loop_active      <= 1'b0;
            iter_start_pulse <= 1'b0;
            iter_end_pulse   <= 1'b0;
            start_count      <= '0;
            end_count        <= '0;
            inflight         <= '0;
            invocations      <= '0;
            loop_done        <= 1'b0;
            err_underflow    <= 1'b0;
            err_overflow     <= 1'b0;
            err_incomplete   <= 1'b0;
            err_protocol     <= 1'b0;
        end else begin
            state            <= nxt_state;
            loop_active      <= (nxt_state == S_LOOP) || (nxt_state == S_DRAIN);
            iter_start_pulse <= nxt_sp;
            iter_end_pulse   <= nxt_ep;
            start_count      <= nxt_sc;
            end_count        <= nxt_ec;
            inflight         <= nxt_inf;
            invocations      <= nxt_inv;
            loop_done        <= nxt_done;
            err_underflow    <= nxt_under;
            err_overflow     <= nxt_over;
            err_incomplete   <= nxt_inc;
            err_protocol     <= nxt_prot;
        end
    end

endmodule
